// File: rtl/vmem_dma_pkg.sv
// rtl/vmem_dma_pkg.sv - shared state encoding and dump FIFO sizing
package vmem_dma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DUMP  = 2'd2,
    ST_DRAIN = 2'd3
  } dma_state_t;

  localparam int FIFO_DEPTH = 3;
  localparam int FIFO_CNT_W = 2;

  // Circular pointer advance over the FIFO slots
  function automatic logic [FIFO_CNT_W-1:0] fifo_ptr_next(input logic [FIFO_CNT_W-1:0] p);
    return (p == FIFO_CNT_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_CNT_W'(1);
  endfunction

endpackage

// File: rtl/vmem_dma_fifo.sv
// rtl/vmem_dma_fifo.sv - three-entry dump FIFO with push/pop/count
module vmem_dma_fifo
  import vmem_dma_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      head,
  output logic [FIFO_CNT_W-1:0] count
);

  logic [WIDTH-1:0]      slots [FIFO_DEPTH];
  logic [FIFO_CNT_W-1:0] rd_ptr;
  logic [FIFO_CNT_W-1:0] wr_ptr;

  // Slot storage needs no reset: count decides what is visible
  always_ff @(posedge clk) begin
    if (push) begin
      slots[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; push together with pop keeps count unchanged
  always_ff @(posedge clk) begin
    if (resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= fifo_ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= fifo_ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + FIFO_CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - FIFO_CNT_W'(1);
      end
    end
  end

  assign head = slots[rd_ptr];

endmodule

// File: rtl/vmem_local_dma.sv
// rtl/vmem_local_dma.sv - row DMA between a stream and the lane memories' port B
module vmem_local_dma
  import vmem_dma_pkg::*;
#(
  parameter int NUMLANES     = 8,
  parameter int DATAWORDSIZE = 16,
  parameter int MEMDEPTH     = 2048,
  parameter int LOGMEMDEPTH  = $clog2(MEMDEPTH)
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_dir,
  input  logic [LOGMEMDEPTH-1:0]            cmd_addr,
  input  logic [LOGMEMDEPTH:0]              cmd_rows,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUMLANES*DATAWORDSIZE-1:0]  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUMLANES*DATAWORDSIZE-1:0]  out_data,
  output logic [NUMLANES*LOGMEMDEPTH-1:0]   mem_address_b,
  output logic                              mem_rden_b,
  output logic                              mem_wren_b,
  output logic [NUMLANES*DATAWORDSIZE-1:0]  mem_data_b,
  input  logic [NUMLANES*DATAWORDSIZE-1:0]  mem_out_b,
  output logic                              busy,
  output logic                              done
);

  localparam int RW = LOGMEMDEPTH + 1;
  localparam int OW = FIFO_CNT_W + 1;

  dma_state_t              state;
  logic [LOGMEMDEPTH-1:0]  row_ptr;
  logic [LOGMEMDEPTH-1:0]  row_next;
  logic [RW-1:0]           remaining;
  logic                    inflight;
  logic                    done_q;
  logic                    last_row;
  logic                    accept;
  logic                    fill_beat;
  logic                    issue;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic [OW-1:0]           occupancy;

  // Row pointer wraps at MEMDEPTH, which need not be a power of two
  assign row_next  = (row_ptr == LOGMEMDEPTH'(MEMDEPTH - 1)) ? '0 : row_ptr + LOGMEMDEPTH'(1);
  assign last_row  = (remaining == RW'(1));

  // Reads in flight count against FIFO space so a returning row always fits
  assign occupancy = {1'b0, fifo_count} + {{FIFO_CNT_W{1'b0}}, inflight};

  assign cmd_ready = (state == ST_IDLE) && !resetn;
  assign accept    = cmd_valid && cmd_ready;
  assign in_ready  = (state == ST_FILL) && !resetn;
  assign fill_beat = in_ready && in_valid;
  assign issue     = (state == ST_DUMP) && (occupancy < OW'(FIFO_DEPTH)) && !resetn;

  assign mem_address_b = {NUMLANES{row_ptr}};
  assign mem_wren_b    = fill_beat;
  assign mem_rden_b    = issue;
  assign mem_data_b    = in_data;

  // A read issued last cycle lands now; reset discards it
  assign fifo_push = inflight && !resetn;
  assign fifo_pop  = out_valid && out_ready;

  assign out_valid = (fifo_count != '0) && !resetn;
  assign busy      = (state != ST_IDLE) && !resetn;
  assign done      = done_q && !resetn;

  vmem_dma_fifo #(
    .WIDTH(NUMLANES * DATAWORDSIZE)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (mem_out_b),
    .pop       (fifo_pop),
    .head      (out_data),
    .count     (fifo_count)
  );

  // Command sequencing: accept, stream rows, drain returning reads, pulse done
  always_ff @(posedge clk) begin
    if (resetn) begin
      state     <= ST_IDLE;
      row_ptr   <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      inflight <= issue;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            row_ptr   <= cmd_addr;
            remaining <= cmd_rows;
            if (cmd_rows == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= cmd_dir ? ST_DUMP : ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (fill_beat) begin
            row_ptr   <= row_next;
            remaining <= remaining - RW'(1);
            if (last_row) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        ST_DUMP: begin
          if (issue) begin
            row_ptr   <= row_next;
            remaining <= remaining - RW'(1);
            if (last_row) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if ((fifo_count == '0) && !inflight) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_local_dma.sv
// tb/tb_vmem_local_dma.sv - self-checking bench for vmem_local_dma
module tb_vmem_local_dma;

  localparam int NL  = 8;
  localparam int DW  = 16;
  localparam int MD  = 2048;
  localparam int LMD = 11;
  localparam int W   = NL * DW;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_dir = 1'b0;
  logic [LMD-1:0]    cmd_addr = '0;
  logic [LMD:0]      cmd_rows = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_data;
  logic [NL*LMD-1:0] mem_address_b;
  logic              mem_rden_b;
  logic              mem_wren_b;
  logic [W-1:0]      mem_data_b;
  logic [W-1:0]      mem_out_b;
  logic              busy;
  logic              done;

  logic              init_we = 1'b0;
  logic [LMD-1:0]    init_addr = '0;
  logic [W-1:0]      init_data = '0;

  logic [W-1:0] ram [MD];
  logic [W-1:0] ref_mem [MD];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vmem_local_dma #(
    .NUMLANES(NL), .DATAWORDSIZE(DW), .MEMDEPTH(MD), .LOGMEMDEPTH(LMD)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_rows(cmd_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_address_b(mem_address_b), .mem_rden_b(mem_rden_b), .mem_wren_b(mem_wren_b),
    .mem_data_b(mem_data_b), .mem_out_b(mem_out_b),
    .busy(busy), .done(done)
  );

  // Per-lane port-B memory: each lane uses its own address slice
  always @(posedge clk) begin
    if (init_we) begin
      ram[init_addr] <= init_data;
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (mem_wren_b) ram[mem_address_b[l*LMD +: LMD]][l*DW +: DW] <= mem_data_b[l*DW +: DW];
        if (mem_rden_b) mem_out_b[l*DW +: DW] <= ram[mem_address_b[l*LMD +: LMD]][l*DW +: DW];
      end
    end
  end

  function automatic bit lanes_at(input logic [NL*LMD-1:0] a, input int row);
    for (int l = 0; l < NL; l++) begin
      if (a[l*LMD +: LMD] !== LMD'(row)) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [W-1:0] rand_row();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic init_memory();
    init_we = 1'b1;
    for (int i = 0; i < MD; i++) begin
      init_addr = LMD'(i);
      init_data = rand_row();
      ref_mem[i] = init_data;
      step();
    end
    init_we = 1'b0;
  endtask

  task automatic send_cmd(input bit dir, input int addr, input int rows);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_addr  = LMD'(addr);
    cmd_rows  = (LMD+1)'(rows);
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 0 || busy !== 0 || done !== 0 || out_valid !== 0 || in_ready !== 0 ||
        mem_rden_b !== 0 || mem_wren_b !== 0) begin
      errors++;
      $display("FAIL reset_outputs: cmd_ready=%b busy=%b done=%b out_valid=%b in_ready=%b rden=%b wren=%b required all 0",
               cmd_ready, busy, done, out_valid, in_ready, mem_rden_b, mem_wren_b);
    end
    step();
    resetn = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL reset_release: cmd_ready=%b busy=%b done=%b required 1 0 0", cmd_ready, busy, done);
    end
    step();
  endtask

  task automatic test_fill(input int addr, input int rows, input bit gaps);
    int beats = 0;
    int cyc = 0;
    int row;
    send_cmd(1'b0, addr, rows);
    while (beats < rows && cyc < rows * 4 + 20) begin
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = rand_row();
      #1;
      checks++;
      if (in_ready !== 1 || mem_rden_b !== 0 || mem_wren_b !== in_valid || busy !== 1 || cmd_ready !== 0) begin
        errors++;
        $display("FAIL fill_ctrl: in_ready=%b rden=%b wren=%b busy=%b cmd_ready=%b required 1 0 %b 1 0",
                 in_ready, mem_rden_b, mem_wren_b, busy, cmd_ready, in_valid);
      end
      if (in_valid) begin
        row = (addr + beats) % MD;
        checks++;
        if (!lanes_at(mem_address_b, row) || mem_data_b !== in_data) begin
          errors++;
          $display("FAIL fill_beat: addr=%h data=%h required row %0d data %h", mem_address_b, mem_data_b, row, in_data);
        end
        ref_mem[row] = in_data;
        beats++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checks++;
    if (beats != rows) begin
      errors++;
      $display("FAIL fill_timeout: beats=%0d required %0d", beats, rows);
    end
    #1;
    checks++;
    if (done !== 1 || busy !== 0 || cmd_ready !== 1 || in_ready !== 0) begin
      errors++;
      $display("FAIL fill_done: done=%b busy=%b cmd_ready=%b in_ready=%b required 1 0 1 0", done, busy, cmd_ready, in_ready);
    end
    step();
    #1;
    checks++;
    if (done !== 0) begin
      errors++;
      $display("FAIL fill_done_pulse: done=%b required 0", done);
    end
    step();
  endtask

  // mode 0: out_ready held high; 1: pattern 1,0,0,1; 2: random
  task automatic test_dump(input int addr, input int rows, input int mode);
    int issued = 0, popped = 0, cyc = 0, nval = 0;
    int first_iss = -1, last_iss = -1, first_val = -1, last_val = -1;
    bit finished = 1'b0;
    send_cmd(1'b1, addr, rows);
    while (!finished && cyc < rows * 6 + 40) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      checks++;
      if (mem_wren_b !== 0 || in_ready !== 0 || cmd_ready !== done || busy !== !done) begin
        errors++;
        $display("FAIL dump_ctrl: wren=%b in_ready=%b cmd_ready=%b busy=%b done=%b", mem_wren_b, in_ready, cmd_ready, busy, done);
      end
      if (mem_rden_b) begin
        checks++;
        if (issued >= rows || !lanes_at(mem_address_b, (addr + issued) % MD)) begin
          errors++;
          $display("FAIL dump_issue: addr=%h issued=%0d required row %0d of %0d", mem_address_b, issued, (addr + issued) % MD, rows);
        end
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
        issued++;
      end
      checks++;
      if (issued - popped > 3) begin
        errors++;
        $display("FAIL dump_outstanding: outstanding=%0d required <=3", issued - popped);
      end
      if (out_valid) begin
        if (first_val < 0) first_val = cyc;
        last_val = cyc;
        nval++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (popped >= rows || out_data !== ref_mem[(addr + popped) % MD]) begin
          errors++;
          $display("FAIL dump_data: row %0d got %h required %h", popped, out_data, ref_mem[(addr + popped) % MD]);
        end
        popped++;
      end
      if (done) finished = 1'b1;
      step();
      cyc++;
    end
    out_ready = 1'b0;
    checks++;
    if (!finished || issued != rows || popped != rows) begin
      errors++;
      $display("FAIL dump_complete: done_seen=%b issued=%0d popped=%0d required 1 %0d %0d", finished, issued, popped, rows, rows);
    end
    #1;
    checks++;
    if (done !== 0 || busy !== 0 || out_valid !== 0) begin
      errors++;
      $display("FAIL dump_done_once: done=%b busy=%b out_valid=%b required 0 0 0", done, busy, out_valid);
    end
    if (mode == 0) begin
      checks++;
      if (first_val - first_iss != 2 || last_iss - first_iss != rows - 1 || nval != rows || last_val - first_val != rows - 1) begin
        errors++;
        $display("FAIL dump_timing: latency=%0d issue_span=%0d valid_cycles=%0d valid_span=%0d required 2 %0d %0d %0d",
                 first_val - first_iss, last_iss - first_iss, nval, last_val - first_val, rows - 1, rows, rows - 1);
      end
    end
    step();
  endtask

  task automatic test_zero_rows(input bit dir);
    send_cmd(dir, 77, 0);
    in_valid = 1'b1;
    in_data  = rand_row();
    #1;
    checks++;
    if (done !== 1 || busy !== 0 || mem_rden_b !== 0 || mem_wren_b !== 0 || in_ready !== 0) begin
      errors++;
      $display("FAIL zero_rows_done: done=%b busy=%b rden=%b wren=%b in_ready=%b required 1 0 0 0 0",
               done, busy, mem_rden_b, mem_wren_b, in_ready);
    end
    step();
    #1;
    checks++;
    if (done !== 0 || mem_rden_b !== 0 || mem_wren_b !== 0) begin
      errors++;
      $display("FAIL zero_rows_after: done=%b rden=%b wren=%b required 0 0 0", done, mem_rden_b, mem_wren_b);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_dump();
    out_ready = 1'b0;
    send_cmd(1'b1, 100, 4);
    #1;
    checks++;
    if (mem_rden_b !== 1 || !lanes_at(mem_address_b, 100)) begin
      errors++;
      $display("FAIL abort_first_read: rden=%b addr=%h required 1 row 100", mem_rden_b, mem_address_b);
    end
    step();
    resetn = 1'b1;
    #1;
    checks++;
    if (out_valid !== 0 || busy !== 0 || cmd_ready !== 0 || mem_rden_b !== 0 || done !== 0) begin
      errors++;
      $display("FAIL abort_in_reset: out_valid=%b busy=%b cmd_ready=%b rden=%b done=%b required all 0",
               out_valid, busy, cmd_ready, mem_rden_b, done);
    end
    step();
    #1;
    checks++;
    if (out_valid !== 0 || busy !== 0 || done !== 0) begin
      errors++;
      $display("FAIL abort_next: out_valid=%b busy=%b done=%b required 0 0 0", out_valid, busy, done);
    end
    resetn = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (cmd_ready !== 1 || done !== 0 || out_valid !== 0 || busy !== 0) begin
        errors++;
        $display("FAIL abort_after: cycle %0d cmd_ready=%b done=%b out_valid=%b busy=%b required 1 0 0 0",
                 i, cmd_ready, done, out_valid, busy);
      end
      step();
    end
  endtask

  task automatic test_random();
    int addr, rows;
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 2) == 0) addr = MD - 1 - int'($urandom_range(0, 5));
      else addr = int'($urandom_range(0, MD - 1));
      rows = int'($urandom_range(1, 20));
      test_fill(addr, rows, 1'b1);
      test_dump((addr + int'($urandom_range(0, 3))) % MD, rows, 2);
    end
  endtask

  initial begin
    @(negedge clk);
    init_memory();
    test_reset();
    test_fill(5, 3, 1'b0);
    test_dump(5, 3, 0);
    test_dump(2046, 4, 0);
    test_dump(10, 6, 1);
    test_zero_rows(1'b0);
    test_zero_rows(1'b1);
    test_reset_mid_dump();
    test_dump(100, 4, 2);
    test_fill(2045, 6, 1'b0);
    test_dump(2044, 8, 1);
    test_random();
    test_dump(0, MD, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
